// File: rtl/lc3b_load_ext.sv
// Registered load-extract unit: one memory read per byte/word load, lane select and zero/sign extension.
// Optional misaligned-word trap is enabled with `define LOAD_EXT_MISALIGN_TRAP_EN.
module lc3b_load_ext #(
   parameter int DATA_WIDTH = 16,
   parameter int LANE_WIDTH = 8,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  byteword,
   input  logic                  zextsext,
   output logic                  mem_read,
   output logic [ADDR_WIDTH-1:0] mem_address,
   input  logic                  mem_resp,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_err
);

   localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
   localparam int LANE_BITS = $clog2(NUM_LANES);

   typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [LANE_BITS-1:0]    lane_q, lane_d;
   logic                    byteword_q, byteword_d;
   logic                    zextsext_q, zextsext_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    err_q, err_d;

   logic [LANE_WIDTH-1:0]   lane_byte;
   logic [DATA_WIDTH-1:0]   ext_data;

   always_comb begin
      lane_byte = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (lane_q == LANE_BITS'(i)) lane_byte = mem_rdata[i*LANE_WIDTH +: LANE_WIDTH];
      end
      if (byteword_q) ext_data = mem_rdata;
      else ext_data = {{(DATA_WIDTH-LANE_WIDTH){zextsext_q & lane_byte[LANE_WIDTH-1]}}, lane_byte};
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      lane_d     = lane_q;
      byteword_d = byteword_q;
      zextsext_d = zextsext_q;
      data_d     = data_q;
      err_d      = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d     = {req_addr[ADDR_WIDTH-1:LANE_BITS], {LANE_BITS{1'b0}}};
               lane_d     = req_addr[LANE_BITS-1:0];
               byteword_d = byteword;
               zextsext_d = zextsext;
               state_d    = MEM;
`ifdef LOAD_EXT_MISALIGN_TRAP_EN
               // misaligned word: skip memory entirely and report an error result
               if (byteword && (req_addr[LANE_BITS-1:0] != '0)) begin
                  state_d = RESP;
                  data_d  = '0;
                  err_d   = 1'b1;
               end
`endif
            end
         end
         MEM: begin
            if (mem_resp) begin
               data_d  = ext_data;
               state_d = RESP;
            end
         end
         RESP: begin
            if (out_ready) begin
               state_d = IDLE;
               err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         lane_q     <= '0;
         byteword_q <= 1'b0;
         zextsext_q <= 1'b0;
         data_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         lane_q     <= lane_d;
         byteword_q <= byteword_d;
         zextsext_q <= zextsext_d;
         data_q     <= data_d;
         err_q      <= err_d;
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign mem_read    = (state_q == MEM);
   assign out_valid   = (state_q == RESP);
   assign mem_address = addr_q;
   assign out_data    = data_q;
`ifdef LOAD_EXT_MISALIGN_TRAP_EN
   assign out_err     = err_q;
`else
   assign out_err     = 1'b0;
`endif

endmodule

// File: tb/tb_lc3b_load_ext.sv
// Directed-vector bench for lc3b_load_ext (16-bit data, 8-bit lanes).
module tb_lc3b_load_ext;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_addr;
   logic        byteword;
   logic        zextsext;
   logic        mem_read;
   logic [15:0] mem_address;
   logic        mem_resp;
   logic [15:0] mem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lc3b_load_ext #(.DATA_WIDTH(16), .LANE_WIDTH(8), .ADDR_WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .byteword(byteword), .zextsext(zextsext),
      .mem_read(mem_read), .mem_address(mem_address), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // full load: accept, hold MEM for waits+1 cycles, check result, drain
   task automatic do_load(input logic [15:0] a, input logic bw, input logic zs, input int waits,
                          input logic [15:0] rdata, input logic [15:0] exp_addr, input logic [15:0] exp_data);
      chk("idle_ready", req_ready, 1);
      req_valid = 1; req_addr = a; byteword = bw; zextsext = zs;
      tick();
      req_valid = 0;
      for (int w = 0; w <= waits; w++) begin
         chk("mem_read", mem_read, 1);
         chk("mem_addr", mem_address, exp_addr);
         chk("busy_ready", req_ready, 0);
         chk("no_valid", out_valid, 0);
         if (w == waits) begin
            mem_resp = 1; mem_rdata = rdata;
         end
         tick();
         mem_resp = 0; mem_rdata = 16'hDEAD;
      end
      chk("rd_drop", mem_read, 0);
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, exp_data);
      chk("out_err", out_err, 0);
      out_ready = 1;
      tick();
      out_ready = 0;
      chk("valid_fall", out_valid, 0);
      chk("ready_rise", req_ready, 1);
   endtask

   initial begin
      rst = 1; req_valid = 0; req_addr = 0; byteword = 0; zextsext = 0;
      mem_resp = 0; mem_rdata = 16'hDEAD; out_ready = 0;
      tick(); tick();
      rst = 0;
      chk("rst_ready", req_ready, 1);
      chk("rst_read", mem_read, 0);
      chk("rst_addr", mem_address, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_err", out_err, 0);
      tick();

      do_load(16'h3001, 0, 1, 0, 16'h80F0, 16'h3000, 16'hFF80);
      do_load(16'h3000, 0, 0, 0, 16'h80F0, 16'h3000, 16'h00F0);
      do_load(16'h3000, 0, 1, 0, 16'h80F0, 16'h3000, 16'hFFF0);
      do_load(16'h3001, 0, 0, 1, 16'hFF12, 16'h3000, 16'h00FF);
      do_load(16'h5003, 0, 1, 0, 16'h7F12, 16'h5002, 16'h007F);
      do_load(16'h4002, 1, 1, 3, 16'hBEEF, 16'h4002, 16'hBEEF);

      // backpressure with a pending request
      req_valid = 1; req_addr = 16'h2000; byteword = 1; zextsext = 0;
      tick();
      req_addr = 16'h2222;
      mem_resp = 1; mem_rdata = 16'h1357;
      tick();
      mem_resp = 0; mem_rdata = 16'hDEAD;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", out_valid, 1);
         chk("bp_data", out_data, 16'h1357);
         chk("bp_ready", req_ready, 0);
         chk("bp_read", mem_read, 0);
         tick();
      end
      out_ready = 1;
      tick();
      out_ready = 0;
      chk("bp_valid_fall", out_valid, 0);
      chk("bp_ready_rise", req_ready, 1);
      tick();
      req_valid = 0;
      chk("bp_next_read", mem_read, 1);
      chk("bp_next_addr", mem_address, 16'h2222);
      mem_resp = 1; mem_rdata = 16'h2468;
      tick();
      mem_resp = 0;
      chk("bp_next_data", out_data, 16'h2468);
      out_ready = 1;
      tick();
      out_ready = 0;

      // reset while waiting on memory; late mem_resp must be ignored
      req_valid = 1; req_addr = 16'h6000; byteword = 1;
      tick();
      req_valid = 0;
      chk("mr_read", mem_read, 1);
      rst = 1;
      tick();
      rst = 0;
      chk("mr_read_drop", mem_read, 0);
      chk("mr_ready", req_ready, 1);
      tick();
      mem_resp = 1; mem_rdata = 16'hAAAA;
      tick();
      mem_resp = 0;
      for (int i = 0; i < 3; i++) begin
         chk("mr_no_valid", out_valid, 0);
         chk("mr_no_read", mem_read, 0);
         tick();
      end
      chk("mr_data", out_data, 0);

      // misaligned word load
`ifdef LOAD_EXT_MISALIGN_TRAP_EN
      req_valid = 1; req_addr = 16'h4001; byteword = 1; zextsext = 0;
      tick();
      req_valid = 0;
      chk("mis_no_read", mem_read, 0);
      chk("mis_valid", out_valid, 1);
      chk("mis_err", out_err, 1);
      chk("mis_data", out_data, 0);
      out_ready = 1;
      tick();
      out_ready = 0;
      chk("mis_err_clr", out_err, 0);
      chk("mis_valid_fall", out_valid, 0);
`else
      do_load(16'h4001, 1, 0, 0, 16'h1234, 16'h4000, 16'h1234);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
